seven_segment_capture: RTL



---
 rtl/seven_segment_pkg.sv | 46 ++++
 rtl/seven_segment_encode.sv | 21 ++
 rtl/seven_segment_capture.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: the active-low {g,f,e,d,c,b,a} glyph table,
// capture FSM states and the anode index helper.
package seven_segment_pkg;

   localparam int MAX_DIGITS = 32;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0011000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b0100111;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   localparam logic [6:0] SEG_TABLE [16] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
      SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
   };

   typedef enum logic {
      SETTLE,
      HELD
   } capture_state_t;

   // Position of the low bit; only meaningful when exactly one bit is low.
   function automatic int unsigned onehot_low_index(input logic [MAX_DIGITS-1:0] anodesPadded);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (!anodesPadded[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/seven_segment_encode.sv
// Reverse glyph lookup: 7-bit active-low segment pattern to {valid, nibble}.
module seven_segment_encode
   import seven_segment_pkg::*;
(
   input  logic [6:0] i_pattern,
   output logic       o_valid,
   output logic [3:0] o_nibble
);

   always_comb begin
      o_valid  = 1'b0;
      o_nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (i_pattern == SEG_TABLE[i]) begin
            o_valid  = 1'b1;
            o_nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers hex digits from a multiplexed seven-segment bus after a stability window.
// Define SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN to add per-digit refresh timeouts.
module seven_segment_capture
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1_000_000
`endif
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [6:0]                    segments,
   input  logic [NUM_DIGITS-1:0]         anodes,
   input  logic                          clearError,
   output logic [4*NUM_DIGITS-1:0]       digits,
   output logic [NUM_DIGITS-1:0]         digitValid,
   output logic                          update,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] updateIndex,
   output logic                          patternError,
   output logic                          anodeError
);

   localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SAMPLE_W = NUM_DIGITS + 7;
   localparam logic [7:0] STABLE_COUNT = 8'(STABLE_CYCLES);

   logic [SAMPLE_W-1:0]   w_busNow;
   logic [SAMPLE_W-1:0]   r_sample;
   logic [7:0]            r_count;
   logic [7:0]            w_countNext;
   logic                  w_same;
   logic                  w_evaluate;
   capture_state_t        r_state;
   capture_state_t        w_stateNext;

   logic                  r_evalPending;
   logic [NUM_DIGITS-1:0] r_evalAnodes;
   logic [6:0]            r_evalSeg;

   logic [MAX_DIGITS-1:0] w_anodesPadded;
   logic                  w_blank;
   logic                  w_oneHot;
   logic                  w_encValid;
   logic [3:0]            w_encNibble;
   logic [IDX_W-1:0]      w_index;
   logic                  w_capture;
   logic                  w_setPattern;
   logic                  w_setAnode;

   assign w_busNow    = {anodes, segments};
   assign w_same      = (w_busNow == r_sample);
   assign w_countNext = !w_same                  ? 8'd1 :
                        (r_count == STABLE_COUNT) ? r_count :
                                                    r_count + 8'd1;

   // The sample register starts blank so a driven bus after reset counts as a change.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sample <= '1;
         r_count  <= 8'd0;
      end else begin
         r_sample <= w_busNow;
         r_count  <= w_countNext;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SETTLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_evaluate  = 1'b0;
      case (r_state)
         SETTLE: begin
            if (w_same && (w_countNext == STABLE_COUNT)) begin
               w_evaluate  = 1'b1;
               w_stateNext = HELD;
            end
         end
         HELD: begin
            if (!w_same) begin
               w_stateNext = SETTLE;
            end
         end
         default: w_stateNext = SETTLE;
      endcase
   end

   // The evaluated window is staged one cycle so outputs land on the following edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_evalPending <= 1'b0;
         r_evalAnodes  <= '1;
         r_evalSeg     <= '1;
      end else begin
         r_evalPending <= w_evaluate;
         r_evalAnodes  <= r_sample[SAMPLE_W-1:7];
         r_evalSeg     <= r_sample[6:0];
      end
   end

   always_comb begin
      w_anodesPadded                 = '1;
      w_anodesPadded[NUM_DIGITS-1:0] = r_evalAnodes;
   end

   assign w_blank  = &r_evalAnodes;
   assign w_oneHot = $onehot(~r_evalAnodes);
   assign w_index  = IDX_W'(onehot_low_index(w_anodesPadded));

   seven_segment_encode u_encode (
      .i_pattern (r_evalSeg),
      .o_valid   (w_encValid),
      .o_nibble  (w_encNibble)
   );

   assign w_capture    = r_evalPending && w_oneHot && w_encValid;
   assign w_setPattern = r_evalPending && w_oneHot && !w_encValid;
   assign w_setAnode   = r_evalPending && !w_blank && !w_oneHot;

`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT_CYCLES);
   logic [AGE_W-1:0] r_age [NUM_DIGITS];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         digits       <= '0;
         digitValid   <= '0;
         update       <= 1'b0;
         updateIndex  <= '0;
         patternError <= 1'b0;
         anodeError   <= 1'b0;
`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_age[i] <= '0;
         end
`endif
      end else begin
         update       <= w_capture;
         patternError <= w_setPattern | (patternError & ~clearError);
         anodeError   <= w_setAnode | (anodeError & ~clearError);
         if (w_capture) begin
            digits[4*w_index +: 4] <= w_encNibble;
            digitValid[w_index]    <= 1'b1;
            updateIndex            <= w_index;
         end
`ifdef SEVEN_SEGMENT_CAPTURE_TIMEOUT_EN
         // A capture on the timeout cycle keeps the digit valid.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_capture && (w_index == IDX_W'(i))) begin
               r_age[i] <= '0;
            end else if (r_age[i] != AGE_LIMIT) begin
               r_age[i] <= r_age[i] + AGE_W'(1);
               if ((r_age[i] + AGE_W'(1)) == AGE_LIMIT) begin
                  digitValid[i] <= 1'b0;
               end
            end
         end
`endif
      end
   end

endmodule
